// File: rtl/mask_centroid.sv
// mask_centroid: accumulates coordinate sums and the count of skin pixels over a
// frame, then divides them at frame end to give the skin-region centroid.
module mask_centroid #(
  parameter int X_W       = 11,
  parameter int Y_W       = 10,
  parameter int MIN_COUNT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           de,
  input  logic           vsync,
  input  logic [7:0]     mask,
  output logic [X_W-1:0] x_c,
  output logic [Y_W-1:0] y_c,
  output logic           valid,
  output logic           empty,
  output logic           busy,
  output logic           overrun
);

  localparam int CNT_W  = X_W + Y_W;
  localparam int SX_W   = 2 * X_W + Y_W;
  localparam int SY_W   = X_W + 2 * Y_W;
  localparam int DIV_N  = (SX_W > SY_W) ? SX_W : SY_W;
  localparam int STEP_W = $clog2(DIV_N + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               de_q, de_d, de_dly_q, de_dly_d;
  logic               vsync_q, vsync_d, vsync_dly_q, vsync_dly_d;
  logic               skin_q, skin_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [SX_W-1:0]    sum_x_q, sum_x_d;
  logic [SY_W-1:0]    sum_y_q, sum_y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_N-1:0]   num_x_q, num_x_d, num_y_q, num_y_d;
  logic [CNT_W-1:0]   rem_x_q, rem_x_d, rem_y_q, rem_y_d;
  logic [CNT_W-1:0]   den_q, den_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               run_q, run_d;
  logic [X_W-1:0]     x_c_q, x_c_d;
  logic [Y_W-1:0]     y_c_q, y_c_d;
  logic               valid_q, valid_d, empty_q, empty_d;
  logic               busy_q, busy_d, overrun_q, overrun_d;
  logic               frame_end, line_end, pixel;
  logic [CNT_W:0]     rem_x_sh, rem_y_sh;

  // Next-state logic: input stage, coordinate counters, accumulators and divider FSM
  always_comb begin
    de_d        = de;
    skin_d      = |mask;
    vsync_d     = vsync;
    de_dly_d    = de_q;
    vsync_dly_d = vsync_q;

    frame_end = vsync_q & ~vsync_dly_q;
    line_end  = ~de_q & de_dly_q;
    pixel     = de_q & skin_q;

    x_d = x_q;
    y_d = y_q;
    if (frame_end) begin
      x_d = '0;
      y_d = '0;
    end else if (line_end) begin
      x_d = '0;
      y_d = y_q + Y_W'(1);
    end else if (de_q) begin
      x_d = x_q + X_W'(1);
    end

    sum_x_d = (frame_end ? '0 : sum_x_q) + (pixel ? SX_W'(x_q) : '0);
    sum_y_d = (frame_end ? '0 : sum_y_q) + (pixel ? SY_W'(y_q) : '0);
    cnt_d   = (frame_end ? '0 : cnt_q) + CNT_W'(pixel);

    rem_x_sh = {rem_x_q, num_x_q[DIV_N-1]};
    rem_y_sh = {rem_y_q, num_y_q[DIV_N-1]};

    state_d   = state_q;
    num_x_d   = num_x_q;
    num_y_d   = num_y_q;
    rem_x_d   = rem_x_q;
    rem_y_d   = rem_y_q;
    den_d     = den_q;
    step_d    = step_q;
    run_d     = run_q;
    x_c_d     = x_c_q;
    y_c_d     = y_c_q;
    empty_d   = empty_q;
    valid_d   = 1'b0;
    overrun_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_end) begin
          num_x_d = DIV_N'(sum_x_q);
          num_y_d = DIV_N'(sum_y_q);
          den_d   = cnt_q;
          rem_x_d = '0;
          rem_y_d = '0;
          run_d   = (cnt_q >= CNT_W'(MIN_COUNT));
          step_d  = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (run_q) begin
          if (rem_x_sh >= {1'b0, den_q}) begin
            rem_x_d = CNT_W'(rem_x_sh - {1'b0, den_q});
            num_x_d = {num_x_q[DIV_N-2:0], 1'b1};
          end else begin
            rem_x_d = rem_x_sh[CNT_W-1:0];
            num_x_d = {num_x_q[DIV_N-2:0], 1'b0};
          end
          if (rem_y_sh >= {1'b0, den_q}) begin
            rem_y_d = CNT_W'(rem_y_sh - {1'b0, den_q});
            num_y_d = {num_y_q[DIV_N-2:0], 1'b1};
          end else begin
            rem_y_d = rem_y_sh[CNT_W-1:0];
            num_y_d = {num_y_q[DIV_N-2:0], 1'b0};
          end
        end
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(DIV_N - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        valid_d = 1'b1;
        if (run_q) begin
          x_c_d   = num_x_q[X_W-1:0];
          y_c_d   = num_y_q[Y_W-1:0];
          empty_d = 1'b0;
        end else begin
          empty_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_end && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State registers; a reset mid-division simply abandons the pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      de_q        <= 1'b0;
      de_dly_q    <= 1'b0;
      vsync_q     <= 1'b0;
      vsync_dly_q <= 1'b0;
      skin_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      sum_x_q     <= '0;
      sum_y_q     <= '0;
      cnt_q       <= '0;
      num_x_q     <= '0;
      num_y_q     <= '0;
      rem_x_q     <= '0;
      rem_y_q     <= '0;
      den_q       <= '0;
      step_q      <= '0;
      run_q       <= 1'b0;
      x_c_q       <= '0;
      y_c_q       <= '0;
      valid_q     <= 1'b0;
      empty_q     <= 1'b1;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      de_q        <= de_d;
      de_dly_q    <= de_dly_d;
      vsync_q     <= vsync_d;
      vsync_dly_q <= vsync_dly_d;
      skin_q      <= skin_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sum_x_q     <= sum_x_d;
      sum_y_q     <= sum_y_d;
      cnt_q       <= cnt_d;
      num_x_q     <= num_x_d;
      num_y_q     <= num_y_d;
      rem_x_q     <= rem_x_d;
      rem_y_q     <= rem_y_d;
      den_q       <= den_d;
      step_q      <= step_d;
      run_q       <= run_d;
      x_c_q       <= x_c_d;
      y_c_q       <= y_c_d;
      valid_q     <= valid_d;
      empty_q     <= empty_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign x_c     = x_c_q;
  assign y_c     = y_c_q;
  assign valid   = valid_q;
  assign empty   = empty_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_mask_centroid.sv
// tb_mask_centroid: drives small video frames into mask_centroid and compares the
// reported centroid, empty flag and timing against a frame-level reference model.
`timescale 1ns/1ps
module tb_mask_centroid;

  localparam int X_W = 11;
  localparam int Y_W = 10;
  localparam int MIN_CNT = 64;
  localparam int DIV_N = 32;
  localparam int W = 40;
  localparam int H = 24;
  localparam int HB = 4;
  localparam int VALID_AT = DIV_N + 3;

  logic           clk = 1'b0;
  logic           rst_n, de, vsync;
  logic [7:0]     mask;
  logic [X_W-1:0] x_c;
  logic [Y_W-1:0] y_c;
  logic           valid, empty, busy, overrun;

  int n_checks = 0;
  int n_fail = 0;

  bit             pix [H][W];
  logic [X_W-1:0] exp_xc;
  logic [Y_W-1:0] exp_yc;
  logic           exp_empty;
  int             m_cnt;
  longint         m_sx, m_sy;

  int v_at, n_v, b_cnt, o_at, n_o;

  mask_centroid #(.X_W(X_W), .Y_W(Y_W), .MIN_COUNT(MIN_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .de(de), .vsync(vsync), .mask(mask),
    .x_c(x_c), .y_c(y_c), .valid(valid), .empty(empty), .busy(busy), .overrun(overrun)
  );

  // Free-running pixel clock
  always #5 clk = ~clk;

  task automatic clear_pix();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) pix[y][x] = 1'b0;
  endtask

  task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) pix[y][x] = 1'b1;
  endtask

  task automatic random_pix(input int density);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) pix[y][x] = ($urandom_range(99) < density);
  endtask

  // Reference model: centroid is the mean of the skin coordinates, floored;
  // a frame with too few skin pixels leaves the previous centroid in place.
  task automatic model_frame();
    m_cnt = 0; m_sx = 0; m_sy = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (pix[y][x]) begin
          m_cnt++; m_sx += x; m_sy += y;
        end
    if (m_cnt >= MIN_CNT) begin
      exp_xc = X_W'(m_sx / m_cnt);
      exp_yc = Y_W'(m_sy / m_cnt);
      exp_empty = 1'b0;
    end else begin
      exp_empty = 1'b1;
    end
  endtask

  task automatic send_frame();
    model_frame();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        @(negedge clk);
        de = 1'b1;
        mask = pix[y][x] ? 8'($urandom_range(255, 1)) : 8'h00;
      end
      for (int b = 0; b < HB; b++) begin
        @(negedge clk);
        de = 1'b0;
        mask = 8'($urandom);
      end
    end
    @(negedge clk);
    mask = 8'h00;
  endtask

  // Raises vsync and watches 60 cycles; n counts clock edges after the raise
  task automatic frame_end(input int second_at, input bit junk, output int valid_at,
                           output int nv, output int bc, output int ovr_at, output int no);
    valid_at = -1; nv = 0; bc = 0; ovr_at = -1; no = 0;
    @(negedge clk);
    vsync = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid === 1'b1) begin nv++; if (valid_at < 0) valid_at = n; end
      if (busy === 1'b1) bc++;
      if (overrun === 1'b1) begin no++; if (ovr_at < 0) ovr_at = n; end
      if (n == 3) vsync = 1'b0;
      if (second_at > 0 && n == second_at - 1) vsync = 1'b1;
      if (second_at > 0 && n == second_at + 2) vsync = 1'b0;
      if (junk && n >= 5 && n < 10) begin de = 1'b1; mask = 8'hFF; end
      else begin de = 1'b0; mask = 8'h00; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; de = 1'b0; vsync = 1'b0; mask = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (x_c !== '0) begin n_fail++; $display("[TB] FAIL reset_x_c: got %0d expected 0", x_c); end
    n_checks++; if (y_c !== '0) begin n_fail++; $display("[TB] FAIL reset_y_c: got %0d expected 0", y_c); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    rst_n = 1'b1;
    exp_xc = '0; exp_yc = '0; exp_empty = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_idle: busy=%b valid=%b expected 0 0", busy, valid); end
  endtask

  task automatic test_rect();
    clear_pix();
    set_rect(20, 29, 8, 15);
    send_frame();
    frame_end(0, 1'b0, v_at, n_v, b_cnt, o_at, n_o);
    n_checks++; if (exp_xc !== 11'd24 || exp_yc !== 10'd11) begin n_fail++; $display("[TB] FAIL rect_model: got %0d,%0d expected 24,11", exp_xc, exp_yc); end
    n_checks++; if (v_at != VALID_AT) begin n_fail++; $display("[TB] FAIL rect_latency: got %0d expected %0d", v_at, VALID_AT); end
    n_checks++; if (n_v != 1) begin n_fail++; $display("[TB] FAIL rect_valid_count: got %0d expected 1", n_v); end
    n_checks++; if (b_cnt != DIV_N + 1) begin n_fail++; $display("[TB] FAIL rect_busy_cycles: got %0d expected %0d", b_cnt, DIV_N + 1); end
    n_checks++; if (n_o != 0) begin n_fail++; $display("[TB] FAIL rect_overrun: got %0d expected 0", n_o); end
    n_checks++; if (x_c !== exp_xc) begin n_fail++; $display("[TB] FAIL rect_x_c: got %0d expected %0d", x_c, exp_xc); end
    n_checks++; if (y_c !== exp_yc) begin n_fail++; $display("[TB] FAIL rect_y_c: got %0d expected %0d", y_c, exp_yc); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("[TB] FAIL rect_empty: got %b expected 0", empty); end
  endtask

  task automatic test_empty();
    for (int s = 0; s < 3; s++) begin
      clear_pix();
      if (s == 1) set_rect(0, 8, 0, 6);
      if (s == 2) set_rect(10, 19, 2, 11);
      send_frame();
      frame_end(0, 1'b0, v_at, n_v, b_cnt, o_at, n_o);
      n_checks++; if (v_at != VALID_AT || n_v != 1) begin n_fail++; $display("[TB] FAIL empty%0d_valid: at %0d count %0d expected at %0d count 1", s, v_at, n_v, VALID_AT); end
      n_checks++; if (empty !== exp_empty) begin n_fail++; $display("[TB] FAIL empty%0d_flag: got %b expected %b", s, empty, exp_empty); end
      n_checks++; if (x_c !== exp_xc || y_c !== exp_yc) begin n_fail++; $display("[TB] FAIL empty%0d_xy: got %0d,%0d expected %0d,%0d", s, x_c, y_c, exp_xc, exp_yc); end
    end
  endtask

  task automatic test_random();
    int dens [5] = '{30, 5, 70, 1, 15};
    for (int f = 0; f < 5; f++) begin
      random_pix(dens[f]);
      send_frame();
      frame_end(0, 1'b0, v_at, n_v, b_cnt, o_at, n_o);
      n_checks++; if (v_at != VALID_AT || n_v != 1) begin n_fail++; $display("[TB] FAIL rand%0d_valid: at %0d count %0d expected at %0d count 1", f, v_at, n_v, VALID_AT); end
      n_checks++; if (empty !== exp_empty) begin n_fail++; $display("[TB] FAIL rand%0d_empty: got %b expected %b (count %0d)", f, empty, exp_empty, m_cnt); end
      n_checks++; if (x_c !== exp_xc || y_c !== exp_yc) begin n_fail++; $display("[TB] FAIL rand%0d_xy: got %0d,%0d expected %0d,%0d", f, x_c, y_c, exp_xc, exp_yc); end
    end
  endtask

  task automatic test_overrun();
    clear_pix();
    set_rect(5, 14, 3, 12);
    send_frame();
    frame_end(11, 1'b1, v_at, n_v, b_cnt, o_at, n_o);
    n_checks++; if (n_o != 1 || o_at != 12) begin n_fail++; $display("[TB] FAIL ovr_pulse: count %0d at %0d expected count 1 at 12", n_o, o_at); end
    n_checks++; if (n_v != 1 || v_at != VALID_AT) begin n_fail++; $display("[TB] FAIL ovr_valid: count %0d at %0d expected count 1 at %0d", n_v, v_at, VALID_AT); end
    n_checks++; if (x_c !== exp_xc || y_c !== exp_yc || empty !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_first_xy: got %0d,%0d,%b expected %0d,%0d,0", x_c, y_c, empty, exp_xc, exp_yc); end
    clear_pix();
    set_rect(30, 37, 16, 23);
    send_frame();
    frame_end(0, 1'b0, v_at, n_v, b_cnt, o_at, n_o);
    n_checks++; if (x_c !== exp_xc || y_c !== exp_yc || empty !== exp_empty) begin n_fail++; $display("[TB] FAIL ovr_next_xy: got %0d,%0d,%b expected %0d,%0d,%b", x_c, y_c, empty, exp_xc, exp_yc, exp_empty); end
    n_checks++; if (n_v != 1 || n_o != 0) begin n_fail++; $display("[TB] FAIL ovr_next_pulses: valid %0d overrun %0d expected 1 0", n_v, n_o); end
  endtask

  task automatic test_reset_mid();
    clear_pix();
    set_rect(2, 30, 4, 20);
    send_frame();
    n_v = 0;
    @(negedge clk);
    vsync = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid === 1'b1) n_v++;
      if (n == 3) vsync = 1'b0;
      if (n == 17) begin
        n_checks++;
        if (x_c !== '0 || y_c !== '0 || empty !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || overrun !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL midreset_outputs: got x=%0d y=%0d e=%b b=%b v=%b o=%b expected 0 0 1 0 0 0", x_c, y_c, empty, busy, valid, overrun);
        end
      end
      if (n == 16) rst_n = 1'b0;
      if (n == 18) rst_n = 1'b1;
    end
    n_checks++; if (n_v != 0) begin n_fail++; $display("[TB] FAIL midreset_no_valid: got %0d expected 0", n_v); end
    exp_xc = '0; exp_yc = '0; exp_empty = 1'b1;
    clear_pix();
    set_rect(0, 7, 0, 7);
    send_frame();
    frame_end(0, 1'b0, v_at, n_v, b_cnt, o_at, n_o);
    n_checks++; if (x_c !== 11'd3 || y_c !== 10'd3 || empty !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_next_xy: got %0d,%0d,%b expected 3,3,0", x_c, y_c, empty); end
    n_checks++; if (v_at != VALID_AT || n_v != 1) begin n_fail++; $display("[TB] FAIL midreset_next_valid: at %0d count %0d expected at %0d count 1", v_at, n_v, VALID_AT); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_rect();
    test_empty();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
